// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the unified-memory arbiter.
// State encodings are 2 bits; DEFAULT_LATENCY is the stock memory latency.
package memory_arbiter_pkg;

    localparam int DEFAULT_LATENCY = 2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SERVE_IF  = 2'd1,
        ST_SERVE_MEM = 2'd2,
        ST_DONE      = 2'd3
    } arb_state_e;

endpackage

// File: rtl/memory_arbiter_access_timer.sv
// Loadable down-counter; o_done is high while the count is zero.
// Loaded on entry to a SERVE state, it marks the last memory cycle.
module access_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_done
);

    logic [W-1:0] r_count;

    // Load on grant, otherwise count down and park at zero
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/memory_arbiter.sv
// Arbiter sharing one fixed-latency single-port memory between IF and MEM.
// MEM has strict priority; each access is SERVE for LATENCY cycles then DONE.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int LATENCY    = DEFAULT_LATENCY,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ifReq,
    input  logic [ADDR_WIDTH-1:0] ifAddress,
    output logic                  ifReady,
    output logic [DATA_WIDTH-1:0] ifData,
    input  logic                  memReadReq,
    input  logic                  memWriteReq,
    input  logic [ADDR_WIDTH-1:0] memAddress,
    input  logic [DATA_WIDTH-1:0] memWriteData,
    output logic                  memReady,
    output logic [DATA_WIDTH-1:0] memReadData,
    output logic                  stallFetch,
    output logic                  stallMemory,
    output logic                  ramEnable,
    output logic                  ramWrite,
    output logic [ADDR_WIDTH-1:0] ramAddress,
    output logic [DATA_WIDTH-1:0] ramWriteData,
    input  logic [DATA_WIDTH-1:0] ramReadData
);

    localparam int CW = $clog2(LATENCY + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(LATENCY - 1);

    arb_state_e            r_state;
    logic                  r_if_ready;
    logic                  r_mem_ready;
    logic [DATA_WIDTH-1:0] r_if_data;
    logic [DATA_WIDTH-1:0] r_mem_rdata;
    logic                  r_ram_en;
    logic                  r_ram_wr;
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic [DATA_WIDTH-1:0] r_ram_wdata;

    logic w_mem_req;
    logic w_load;
    logic w_done;

    assign w_mem_req = memReadReq | memWriteReq;
    assign w_load    = (r_state == ST_IDLE) & (w_mem_req | ifReq);

    access_timer #(
        .W (CW)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_value (LOAD_VAL),
        .o_done  (w_done)
    );

    // Arbitration FSM; ram* hold latched request copies while serving
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_if_ready  <= 1'b0;
            r_mem_ready <= 1'b0;
            r_if_data   <= '0;
            r_mem_rdata <= '0;
            r_ram_en    <= 1'b0;
            r_ram_wr    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
        end else begin
            r_if_ready  <= 1'b0;
            r_mem_ready <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_mem_req) begin
                        r_state     <= ST_SERVE_MEM;
                        r_ram_en    <= 1'b1;
                        r_ram_wr    <= memWriteReq;
                        r_ram_addr  <= memAddress;
                        r_ram_wdata <= memWriteData;
                    end else if (ifReq) begin
                        r_state     <= ST_SERVE_IF;
                        r_ram_en    <= 1'b1;
                        r_ram_wr    <= 1'b0;
                        r_ram_addr  <= ifAddress;
                        r_ram_wdata <= '0;
                    end
                end
                ST_SERVE_IF: begin
                    if (w_done) begin
                        r_state     <= ST_DONE;
                        r_if_data   <= ramReadData;
                        r_if_ready  <= 1'b1;
                        r_ram_en    <= 1'b0;
                        r_ram_wr    <= 1'b0;
                        r_ram_addr  <= '0;
                        r_ram_wdata <= '0;
                    end
                end
                ST_SERVE_MEM: begin
                    if (w_done) begin
                        r_state     <= ST_DONE;
                        if (!r_ram_wr) begin
                            r_mem_rdata <= ramReadData;
                        end
                        r_mem_ready <= 1'b1;
                        r_ram_en    <= 1'b0;
                        r_ram_wr    <= 1'b0;
                        r_ram_addr  <= '0;
                        r_ram_wdata <= '0;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ifReady      = r_if_ready;
    assign memReady     = r_mem_ready;
    assign ifData       = r_if_data;
    assign memReadData  = r_mem_rdata;
    assign ramEnable    = r_ram_en;
    assign ramWrite     = r_ram_wr;
    assign ramAddress   = r_ram_addr;
    assign ramWriteData = r_ram_wdata;

    assign stallFetch  = ifReq & ~r_if_ready;
    assign stallMemory = w_mem_req & ~r_mem_ready;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: LATENCY=2 instance for most
// scenarios, LATENCY=1 instance for the held-request fetch stream.
module tb_memory_arbiter;

    logic        clk;
    logic        reset;

    logic        ifReq;
    logic [31:0] ifAddress;
    logic        ifReady;
    logic [31:0] ifData;
    logic        memReadReq;
    logic        memWriteReq;
    logic [31:0] memAddress;
    logic [31:0] memWriteData;
    logic        memReady;
    logic [31:0] memReadData;
    logic        stallFetch;
    logic        stallMemory;
    logic        ramEnable;
    logic        ramWrite;
    logic [31:0] ramAddress;
    logic [31:0] ramWriteData;
    logic [31:0] ramReadData;

    logic        b_ifReq;
    logic [31:0] b_ifAddress;
    logic        b_ifReady;
    logic [31:0] b_ifData;
    logic        b_memReady;
    logic [31:0] b_memReadData;
    logic        b_stallFetch;
    logic        b_stallMemory;
    logic        b_ramEnable;
    logic        b_ramWrite;
    logic [31:0] b_ramAddress;
    logic [31:0] b_ramWriteData;
    logic [31:0] b_ramReadData;

    int n_cmp;
    int n_err;

    memory_arbiter #(
        .LATENCY    (2),
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .ifReq        (ifReq),
        .ifAddress    (ifAddress),
        .ifReady      (ifReady),
        .ifData       (ifData),
        .memReadReq   (memReadReq),
        .memWriteReq  (memWriteReq),
        .memAddress   (memAddress),
        .memWriteData (memWriteData),
        .memReady     (memReady),
        .memReadData  (memReadData),
        .stallFetch   (stallFetch),
        .stallMemory  (stallMemory),
        .ramEnable    (ramEnable),
        .ramWrite     (ramWrite),
        .ramAddress   (ramAddress),
        .ramWriteData (ramWriteData),
        .ramReadData  (ramReadData)
    );

    memory_arbiter #(
        .LATENCY    (1),
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32)
    ) u_dut1 (
        .clk          (clk),
        .reset        (reset),
        .ifReq        (b_ifReq),
        .ifAddress    (b_ifAddress),
        .ifReady      (b_ifReady),
        .ifData       (b_ifData),
        .memReadReq   (1'b0),
        .memWriteReq  (1'b0),
        .memAddress   (32'h0),
        .memWriteData (32'h0),
        .memReady     (b_memReady),
        .memReadData  (b_memReadData),
        .stallFetch   (b_stallFetch),
        .stallMemory  (b_stallMemory),
        .ramEnable    (b_ramEnable),
        .ramWrite     (b_ramWrite),
        .ramAddress   (b_ramAddress),
        .ramWriteData (b_ramWriteData),
        .ramReadData  (b_ramReadData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected per-cycle patterns for the IF+MEM collision (cycles 0..7)
    logic [7:0] t2_en    = 8'b0110_0110;
    logic [7:0] t2_mrdy  = 8'b0000_1000;
    logic [7:0] t2_irdy  = 8'b1000_0000;
    // LATENCY=1 held fetch stream (cycles 0..8)
    logic [8:0] t6_rdy   = 9'b1_0010_0100;
    logic [8:0] t6_en    = 9'b0_1001_0010;

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        ifReq = 1'b0;
        ifAddress = '0;
        memReadReq = 1'b0;
        memWriteReq = 1'b0;
        memAddress = '0;
        memWriteData = '0;
        ramReadData = '0;
        b_ifReq = 1'b0;
        b_ifAddress = '0;
        b_ramReadData = '0;
        tick();
        tick();

        // Reset state
        chk("rst_ramEnable", 64'(ramEnable), 64'd0);
        chk("rst_ifReady", 64'(ifReady), 64'd0);
        chk("rst_memReady", 64'(memReady), 64'd0);
        chk("rst_ifData", 64'(ifData), 64'd0);
        chk("rst_memReadData", 64'(memReadData), 64'd0);
        reset = 1'b0;

        // 1: single fetch, LATENCY=2
        tick();
        ifReq = 1'b1;
        ifAddress = 32'h10;
        ramReadData = 32'hDEADBEEF;
        #1;
        chk("t1_c0_stall", 64'(stallFetch), 64'd1);
        chk("t1_c0_en", 64'(ramEnable), 64'd0);
        tick();
        chk("t1_c1_en", 64'(ramEnable), 64'd1);
        chk("t1_c1_addr", 64'(ramAddress), 64'h10);
        chk("t1_c1_wr", 64'(ramWrite), 64'd0);
        chk("t1_c1_stall", 64'(stallFetch), 64'd1);
        tick();
        chk("t1_c2_en", 64'(ramEnable), 64'd1);
        chk("t1_c2_addr", 64'(ramAddress), 64'h10);
        chk("t1_c2_rdy", 64'(ifReady), 64'd0);
        chk("t1_c2_stall", 64'(stallFetch), 64'd1);
        tick();
        chk("t1_c3_rdy", 64'(ifReady), 64'd1);
        chk("t1_c3_data", 64'(ifData), 64'hDEADBEEF);
        chk("t1_c3_stall", 64'(stallFetch), 64'd0);
        chk("t1_c3_en", 64'(ramEnable), 64'd0);
        ifReq = 1'b0;
        tick();
        chk("t1_c4_rdy", 64'(ifReady), 64'd0);
        chk("t1_c4_en", 64'(ramEnable), 64'd0);

        // 2: IF and MEM collide; MEM first, IF next
        ifReq = 1'b1;
        ifAddress = 32'h20;
        memReadReq = 1'b1;
        memAddress = 32'h80;
        ramReadData = 32'hCAFEF00D;
        #1;
        chk("t2_c0_stallm", 64'(stallMemory), 64'd1);
        chk("t2_c0_stallf", 64'(stallFetch), 64'd1);
        for (int c = 1; c < 8; c++) begin
            tick();
            chk($sformatf("t2_c%0d_en", c), 64'(ramEnable),
                64'(t2_en[c]));
            chk($sformatf("t2_c%0d_mrdy", c), 64'(memReady),
                64'(t2_mrdy[c]));
            chk($sformatf("t2_c%0d_irdy", c), 64'(ifReady),
                64'(t2_irdy[c]));
            if (c == 1) chk("t2_c1_addr", 64'(ramAddress), 64'h80);
            if (c == 5) chk("t2_c5_addr", 64'(ramAddress), 64'h20);
            if (c == 3) begin
                chk("t2_c3_mdata", 64'(memReadData), 64'hCAFEF00D);
                chk("t2_c3_stallf", 64'(stallFetch), 64'd1);
                memReadReq = 1'b0;
                ramReadData = 32'h11111111;
            end
            if (c == 7) begin
                chk("t2_c7_idata", 64'(ifData), 64'h11111111);
                ifReq = 1'b0;
            end
        end

        // 3: store with inputs disturbed mid-access
        tick();
        memWriteReq = 1'b1;
        memAddress = 32'h40;
        memWriteData = 32'h12345678;
        ramReadData = 32'hFFFF0000;
        tick();
        chk("t3_c1_wr", 64'(ramWrite), 64'd1);
        chk("t3_c1_addr", 64'(ramAddress), 64'h40);
        chk("t3_c1_wd", 64'(ramWriteData), 64'h12345678);
        memAddress = 32'h99;
        memWriteData = 32'h0;
        tick();
        chk("t3_c2_wr", 64'(ramWrite), 64'd1);
        chk("t3_c2_addr", 64'(ramAddress), 64'h40);
        chk("t3_c2_wd", 64'(ramWriteData), 64'h12345678);
        tick();
        chk("t3_c3_rdy", 64'(memReady), 64'd1);
        chk("t3_c3_mdata", 64'(memReadData), 64'hCAFEF00D);
        chk("t3_c3_en", 64'(ramEnable), 64'd0);
        memWriteReq = 1'b0;

        // 5: read and write both requested -> write wins
        tick();
        tick();
        memReadReq = 1'b1;
        memWriteReq = 1'b1;
        memAddress = 32'h50;
        memWriteData = 32'hA5A5A5A5;
        tick();
        chk("t5_c1_wr", 64'(ramWrite), 64'd1);
        chk("t5_c1_wd", 64'(ramWriteData), 64'hA5A5A5A5);
        tick();
        tick();
        chk("t5_c3_rdy", 64'(memReady), 64'd1);
        chk("t5_c3_mdata", 64'(memReadData), 64'hCAFEF00D);
        memReadReq = 1'b0;
        memWriteReq = 1'b0;

        // 4: reset during SERVE_MEM, then re-issued load
        tick();
        tick();
        memReadReq = 1'b1;
        memAddress = 32'h44;
        ramReadData = 32'h5555AAAA;
        tick();
        chk("t4_c1_en", 64'(ramEnable), 64'd1);
        reset = 1'b1;
        tick();
        chk("t4_r_en", 64'(ramEnable), 64'd0);
        chk("t4_r_wr", 64'(ramWrite), 64'd0);
        chk("t4_r_addr", 64'(ramAddress), 64'd0);
        chk("t4_r_wd", 64'(ramWriteData), 64'd0);
        chk("t4_r_rdy", 64'(memReady), 64'd0);
        chk("t4_r_mdata", 64'(memReadData), 64'd0);
        reset = 1'b0;
        tick();
        chk("t4_r1_en", 64'(ramEnable), 64'd1);
        chk("t4_r1_rdy", 64'(memReady), 64'd0);
        tick();
        chk("t4_r2_rdy", 64'(memReady), 64'd0);
        tick();
        chk("t4_r3_rdy", 64'(memReady), 64'd1);
        chk("t4_r3_mdata", 64'(memReadData), 64'h5555AAAA);
        memReadReq = 1'b0;

        // 6: LATENCY=1, fetch request held for three fetches
        tick();
        b_ifReq = 1'b1;
        b_ifAddress = 32'h100;
        b_ramReadData = 32'h0BAD0001;
        for (int c = 1; c < 9; c++) begin
            tick();
            chk($sformatf("t6_c%0d_rdy", c), 64'(b_ifReady),
                64'(t6_rdy[c]));
            chk($sformatf("t6_c%0d_en", c), 64'(b_ramEnable),
                64'(t6_en[c]));
            if (c == 2) begin
                chk("t6_d1", 64'(b_ifData), 64'h0BAD0001);
                b_ifAddress = 32'h104;
                b_ramReadData = 32'h0BAD0002;
            end
            if (c == 4) chk("t6_a2", 64'(b_ramAddress), 64'h104);
            if (c == 5) begin
                chk("t6_d2", 64'(b_ifData), 64'h0BAD0002);
                b_ifAddress = 32'h108;
                b_ramReadData = 32'h0BAD0003;
            end
            if (c == 8) begin
                chk("t6_d3", 64'(b_ifData), 64'h0BAD0003);
                b_ifReq = 1'b0;
            end
        end
        tick();
        chk("t6_end_en", 64'(b_ramEnable), 64'd0);
        chk("t6_end_rdy", 64'(b_ifReady), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
